// File: rtl/silife_gen_scheduler.sv
// rtl/silife_gen_scheduler.sv - generation scheduler for the silife cell grid
// Picks the generation trigger, arbitrates the shared BUSY line and runs the stepper/display handshakes.
module silife_gen_scheduler #(
  parameter int PERIOD_W     = 24,
  parameter int GEN_W        = 16,
  parameter int SYNC_TIMEOUT = 4096
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cfg_enable,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic                cfg_disp_en,
  input  logic                cmd_step,
  input  logic                cmd_clear,
  input  logic                sync_active_i,
  input  logic                sync_clk_i,
  input  logic                busy_line_i,
  output logic                busy_oeb_o,
  output logic                step_req_o,
  input  logic                step_done_i,
  output logic                disp_req_o,
  input  logic                disp_done_i,
  output logic [GEN_W-1:0]    gen_count_o,
  output logic [7:0]          overrun_cnt_o,
  output logic                sync_err_o,
  output logic [1:0]          state_o
);

  localparam int TMR_W = $clog2(SYNC_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SYNC = 2'd1,
    STEP      = 2'd2,
    DISPLAY   = 2'd3
  } state_t;

  state_t state, state_next;

  logic [1:0]          sa_sync, sc_sync, bl_sync;
  logic                sa, sc, bl, sc_prev;
  logic [PERIOD_W-1:0] period_cnt, period_last;
  logic                period_tick, sc_rise, tick;
  logic                pending, enter_step;
  logic [TMR_W-1:0]    sync_timer;
  logic                bl_run, bl_ok, timeout_hit;

  // The BUSY line idles released, so its synchroniser comes out of reset high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sa_sync <= 2'b00;
      sc_sync <= 2'b00;
      bl_sync <= 2'b11;
      sc_prev <= 1'b0;
    end else begin
      sa_sync <= {sa_sync[0], sync_active_i};
      sc_sync <= {sc_sync[0], sync_clk_i};
      bl_sync <= {bl_sync[0], busy_line_i};
      sc_prev <= sc;
    end
  end

  assign sa = sa_sync[1];
  assign sc = sc_sync[1];
  assign bl = bl_sync[1];

  assign period_last = (cfg_period == '0) ? '0 : cfg_period - PERIOD_W'(1);
  assign period_tick = !sa && cfg_enable && (period_cnt == period_last);
  assign sc_rise     = sa && sc && !sc_prev;
  assign tick        = period_tick || sc_rise || cmd_step;

  // Equality compare: a counter already past a newly lowered period runs up to all-ones and wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_cnt <= '0;
    end else if (sa || !cfg_enable || (period_cnt == period_last)) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + PERIOD_W'(1);
    end
  end

  assign bl_ok = bl && bl_run;

  always_comb begin
    state_next  = state;
    timeout_hit = 1'b0;
    case (state)
      IDLE:      if (pending) state_next = sa ? WAIT_SYNC : STEP;
      WAIT_SYNC: begin
        if (!sa || bl_ok) begin
          state_next = STEP;
        end else if (sync_timer == TMR_W'(SYNC_TIMEOUT - 1)) begin
          state_next  = STEP;
          timeout_hit = 1'b1;
        end
      end
      STEP:      if (step_done_i) state_next = cfg_disp_en ? DISPLAY : IDLE;
      DISPLAY:   if (disp_done_i) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  assign enter_step = (state_next == STEP) && (state != STEP);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // bl_run remembers the previous BUSY sample taken while waiting for the neighbours.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_timer <= '0;
      bl_run     <= 1'b0;
    end else if (state != WAIT_SYNC) begin
      sync_timer <= '0;
      bl_run     <= 1'b0;
    end else begin
      sync_timer <= sync_timer + TMR_W'(1);
      bl_run     <= bl;
    end
  end

  // A trigger landing on the STEP entry cycle re-arms pending rather than counting as lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending       <= 1'b0;
      overrun_cnt_o <= 8'd0;
    end else begin
      if (enter_step) begin
        pending <= tick;
      end else if (tick) begin
        pending <= 1'b1;
      end
      if (cmd_clear) begin
        overrun_cnt_o <= 8'd0;
      end else if (tick && pending && !enter_step && (overrun_cnt_o != 8'hFF)) begin
        overrun_cnt_o <= overrun_cnt_o + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gen_count_o <= '0;
      sync_err_o  <= 1'b0;
    end else begin
      if (cmd_clear) begin
        gen_count_o <= '0;
      end else if ((state == STEP) && step_done_i) begin
        gen_count_o <= gen_count_o + GEN_W'(1);
      end
      if (cmd_clear) begin
        sync_err_o <= 1'b0;
      end else if (timeout_hit) begin
        sync_err_o <= 1'b1;
      end
    end
  end

  assign step_req_o = (state == STEP);
  assign disp_req_o = (state == DISPLAY);
  assign busy_oeb_o = !(sa && ((state == STEP) || (state == DISPLAY)));
  assign state_o    = state;

endmodule

// File: tb/tb_silife_gen_scheduler.sv
// tb/tb_silife_gen_scheduler.sv - scoreboard bench for silife_gen_scheduler
// Stimulus predicts each generation step; a monitor pops and checks them as step_req_o rises.
module tb_silife_gen_scheduler;

  localparam int GW   = 8;
  localparam int MASK = (1 << GW) - 1;

  logic          clk, reset_n;
  logic          cfg_enable, cfg_disp_en, cmd_step, cmd_clear;
  logic [23:0]   cfg_period;
  logic          sync_active_i, sync_clk_i, busy_line_i;
  logic          busy_oeb_o, step_req_o, step_done_i, disp_req_o, disp_done_i;
  logic [GW-1:0] gen_count_o;
  logic [7:0]    overrun_cnt_o;
  logic          sync_err_o;
  logic [1:0]    state_o;

  silife_gen_scheduler #(.PERIOD_W(24), .GEN_W(GW), .SYNC_TIMEOUT(4096)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_enable(cfg_enable), .cfg_period(cfg_period),
    .cfg_disp_en(cfg_disp_en), .cmd_step(cmd_step), .cmd_clear(cmd_clear),
    .sync_active_i(sync_active_i), .sync_clk_i(sync_clk_i), .busy_line_i(busy_line_i),
    .busy_oeb_o(busy_oeb_o), .step_req_o(step_req_o), .step_done_i(step_done_i),
    .disp_req_o(disp_req_o), .disp_done_i(disp_done_i), .gen_count_o(gen_count_o),
    .overrun_cnt_o(overrun_cnt_o), .sync_err_o(sync_err_o), .state_o(state_o)
  );

  typedef struct {
    int gen;
    int oeb;
  } exp_t;

  exp_t exp_q[$];
  int   rise_cyc[$];
  int   checks = 0, errors = 0;
  int   cyc = 0, nrise = 0, ndisp = 0, last_gen = 0, model_gen = 0;
  int   step_delay = 2, disp_delay = 2;
  logic req_q = 1'b0, dreq_q = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic push_step(input int oeb);
    exp_q.push_back('{gen: model_gen, oeb: oeb});
    model_gen = (model_gen + 1) & MASK;
  endtask

  task automatic pulse_step();
    @(negedge clk); cmd_step = 1'b1;
    @(negedge clk); cmd_step = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk); cmd_clear = 1'b1;
    @(negedge clk); cmd_clear = 1'b0;
    model_gen = 0;
  endtask

  task automatic wait_rises(input int target, input int budget, input string name);
    int n = 0;
    while (nrise < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, (nrise >= target) ? 1 : 0, 1);
  endtask

  task automatic wait_quiet(input int budget, input string name);
    int n = 0, q = 0;
    while (q < 5 && n < budget) begin
      @(negedge clk);
      n++;
      if (state_o == 2'd0 && exp_q.size() == 0) q++;
      else q = 0;
    end
    check(name, (q >= 5) ? 1 : 0, 1);
  endtask

  // Grid stepper and display refresher stand-ins with configurable latency.
  initial begin
    int scnt = 0, dcnt = 0;
    step_done_i = 1'b0;
    disp_done_i = 1'b0;
    forever begin
      @(negedge clk);
      if (step_req_o) begin scnt++; step_done_i = (scnt >= step_delay); end
      else begin scnt = 0; step_done_i = 1'b0; end
      if (disp_req_o) begin dcnt++; disp_done_i = (dcnt >= disp_delay); end
      else begin dcnt = 0; disp_done_i = 1'b0; end
    end
  end

  // Monitor: every new step request must match the oldest predicted step.
  always @(negedge clk) begin
    if (step_req_o && !req_q) begin
      exp_t e;
      rise_cyc.push_back(cyc);
      nrise++;
      if (exp_q.size() == 0) begin
        check("step_expected", 0, 1);
      end else begin
        e = exp_q.pop_front();
        check("step_gen", int'(gen_count_o), e.gen);
        check("step_oeb", int'(busy_oeb_o), e.oeb);
        last_gen = e.gen;
      end
    end
    if (disp_req_o && !dreq_q) begin
      ndisp++;
      check("disp_gen", int'(gen_count_o), (last_gen + 1) & MASK);
      check("disp_step_low", int'(step_req_o), 0);
    end
    req_q  = step_req_o;
    dreq_q = disp_req_o;
  end

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base, n, nd0, d;
    reset_n = 1'b0; cfg_enable = 1'b0; cfg_disp_en = 1'b0; cmd_step = 1'b0; cmd_clear = 1'b0;
    cfg_period = 24'd10; sync_active_i = 1'b0; sync_clk_i = 1'b0; busy_line_i = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_state", state_o, 0);
    check("rst_step_req", step_req_o, 0);
    check("rst_disp_req", disp_req_o, 0);
    check("rst_oeb", busy_oeb_o, 1);
    check("rst_gen", gen_count_o, 0);
    check("rst_overrun", overrun_cnt_o, 0);
    check("rst_sync_err", sync_err_o, 0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // Free-running period of 10 cycles.
    base = rise_cyc.size();
    step_delay = 2;
    for (int i = 0; i < 10; i++) push_step(1);
    cfg_enable = 1'b1;
    wait_rises(nrise + 10, 200, "period_steps");
    cfg_enable = 1'b0;
    wait_quiet(100, "period_quiet");
    check("period_gen", gen_count_o, 10);
    check("period_overrun", overrun_cnt_o, 0);
    for (int i = 1; i < 10; i++)
      check("period_spacing", rise_cyc[base + i] - rise_cyc[base + i - 1], 10);

    // Period 2 against a slow stepper: overruns pile up and saturate, no step lost.
    cfg_period = 24'd2;
    step_delay = 7;
    for (int i = 0; i < 101; i++) push_step(1);
    n = nrise;
    cfg_enable = 1'b1;
    wait_rises(n + 10, 200, "ovr_first");
    check("ovr_grows", (overrun_cnt_o > 0) ? 1 : 0, 1);
    wait_rises(n + 100, 2000, "ovr_steps");
    repeat (3) @(negedge clk);
    cfg_enable = 1'b0;
    wait_quiet(100, "ovr_quiet");
    check("ovr_saturate", overrun_cnt_o, 255);
    check("ovr_gen", gen_count_o, model_gen);
    pulse_clear();
    @(negedge clk);
    check("clear_overrun", overrun_cnt_o, 0);
    check("clear_gen", gen_count_o, 0);

    // Single step followed by a display refresh.
    step_delay = 2; disp_delay = 3; cfg_disp_en = 1'b1;
    nd0 = ndisp;
    push_step(1);
    pulse_step();
    wait_quiet(100, "disp_quiet");
    check("disp_count", ndisp, nd0 + 1);
    check("disp_gen_after", gen_count_o, model_gen);
    cfg_disp_en = 1'b0;

    // cmd_clear on the same cycle the stepper answers.
    step_delay = 3;
    push_step(1);
    pulse_step();
    n = 0;
    while (!step_req_o && n < 20) begin @(negedge clk); n++; end
    check("clrdone_req", step_req_o, 1);
    repeat (2) @(negedge clk);
    cmd_clear = 1'b1;
    @(negedge clk);
    cmd_clear = 1'b0;
    model_gen = 0;
    check("clrdone_gen", gen_count_o, 0);
    wait_quiet(100, "clrdone_quiet");
    step_delay = 2;

    // Sync mode: BUSY held low 50 cycles, then released.
    sync_active_i = 1'b1; busy_line_i = 1'b0; sync_clk_i = 1'b0;
    repeat (4) @(negedge clk);
    push_step(0);
    sync_clk_i = 1'b1;
    n = 0;
    while (state_o != 2'd1 && n < 20) begin @(negedge clk); n++; end
    check("sync_enter_wait", state_o, 1);
    check("sync_wait_oeb", busy_oeb_o, 1);
    d = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (state_o == 2'd1) d++;
    end
    busy_line_i = 1'b1;
    n = 0;
    while (state_o == 2'd1 && n < 20) begin @(negedge clk); n++; if (state_o == 2'd1) d++; end
    check("sync_wait_len", d, 54);
    check("sync_step_state", state_o, 2);
    wait_quiet(100, "sync_quiet");
    check("sync_no_err", sync_err_o, 0);

    // Sync mode with BUSY stuck low: timeout forces the step.
    sync_clk_i = 1'b0; busy_line_i = 1'b0;
    repeat (4) @(negedge clk);
    push_step(0);
    sync_clk_i = 1'b1;
    n = 0;
    while (state_o != 2'd1 && n < 20) begin @(negedge clk); n++; end
    d = 1;
    n = 0;
    while (state_o == 2'd1 && n < 5000) begin @(negedge clk); n++; if (state_o == 2'd1) d++; end
    check("tmo_wait_len", d, 4096);
    check("tmo_sync_err", sync_err_o, 1);
    wait_quiet(100, "tmo_quiet");
    pulse_clear();
    @(negedge clk);
    check("tmo_err_cleared", sync_err_o, 0);
    sync_active_i = 1'b0; sync_clk_i = 1'b0; busy_line_i = 1'b1;
    repeat (4) @(negedge clk);

    // Back-to-back steps at period 1 to wrap gen_count.
    cfg_period = 24'd1; step_delay = 1;
    for (int i = 0; i < 261; i++) push_step(1);
    n = nrise;
    cfg_enable = 1'b1;
    wait_rises(n + 260, 1000, "wrap_steps");
    cfg_enable = 1'b0;
    wait_quiet(100, "wrap_quiet");
    check("wrap_gen", gen_count_o, 261 & MASK);
    pulse_clear();

    // Reset while a step request is outstanding.
    step_delay = 1000;
    push_step(1);
    pulse_step();
    n = 0;
    while (!step_req_o && n < 20) begin @(negedge clk); n++; end
    check("rstmid_req_before", step_req_o, 1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rstmid_req", step_req_o, 0);
    check("rstmid_state", state_o, 0);
    check("rstmid_oeb", busy_oeb_o, 1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_gen = 0;
    step_delay = 2;
    repeat (5) @(negedge clk);
    check("rstmid_gen", gen_count_o, 0);
    check("rstmid_idle", state_o, 0);
    check("sb_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
